// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the PicoSoC bus fabric.
// FSM encoding, error codes and the default error read data.
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MISS    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [31:0] DEF_ERR_RDATA = 32'h0000_0000;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/picosoc_addr_decode.sv
// Base/mask window match with lowest-index priority.
// Purely combinational; hit flags any matching window.
module picosoc_addr_decode
  import picosoc_bus_pkg::*;
#(
  parameter int NSLV = 4,
  parameter logic [NSLV*32-1:0] ADDR_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] ADDR_MASK = {NSLV{32'hFFFF_FFFF}},
  localparam int SW = idx_w(NSLV)
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output logic [SW-1:0] sel
);

  always_comb begin
    hit = 1'b0;
    sel = '0;
    // Walk downwards so the lowest matching index is the last write.
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASK[i*32 +: 32]) == ADDR_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// Single-master, N-slave PicoSoC bus fabric with registered select,
// per-transaction watchdog and sticky error capture.
module picosoc_bus_fabric
  import picosoc_bus_pkg::*;
#(
  parameter int NSLV = 4,
  parameter logic [NSLV*32-1:0] ADDR_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] ADDR_MASK = {NSLV{32'hFFFF_FFFF}},
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [NSLV-1:0]   s_valid,
  output logic [31:0]       s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [NSLV-1:0]   s_ready,
  input  logic [NSLV*32-1:0] s_rdata,
  input  logic              err_clear,
  output logic              err_irq,
  output logic [1:0]        err_code,
  output logic [31:0]       err_addr,
  output logic              err_overrun
);

  localparam int SW = idx_w(NSLV);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] sel;
  logic [CW-1:0] cnt;
  logic [1:0]    rsp_code;
  logic          err_pending;
  logic          dec_hit;
  logic [SW-1:0] dec_sel;
  logic          req;
  logic          rdy;
  logic          tmo;
  logic          ev;

  picosoc_addr_decode #(
    .NSLV      (NSLV),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_MASK (ADDR_MASK)
  ) u_dec (
    .addr (mem_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign req = (state == ST_IDLE) && mem_valid;
  assign rdy = (state == ST_ACTIVE) && s_ready[sel];
  assign tmo = (TIMEOUT != 0) && (state == ST_ACTIVE) && !rdy &&
               (cnt == CW'(TIMEOUT - 1));
  // Errors commit while the response is on the bus.
  assign ev  = (state == ST_RESP) && (rsp_code != ERR_NONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (mem_valid) state_nx = dec_hit ? ST_ACTIVE : ST_RESP;
      ST_ACTIVE: if (rdy || tmo) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == ST_RESP);
    s_valid   = '0;
    if (state == ST_ACTIVE) s_valid[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      rsp_code  <= ERR_NONE;
      mem_rdata <= '0;
    end else begin
      if (req) begin
        sel      <= dec_sel;
        s_addr   <= mem_addr;
        s_wdata  <= mem_wdata;
        s_wstrb  <= mem_wstrb;
        rsp_code <= dec_hit ? ERR_NONE : ERR_MISS;
        if (!dec_hit) mem_rdata <= ERR_RDATA;
      end
      if (rdy) mem_rdata <= s_rdata[32*int'(sel) +: 32];
      if (tmo) begin
        mem_rdata <= ERR_RDATA;
        rsp_code  <= ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        cnt <= '0;
    else if (state != ST_ACTIVE)      cnt <= '0;
    else if (!rdy && (cnt != '1))     cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pending <= 1'b0;
      err_code    <= ERR_NONE;
      err_addr    <= '0;
      err_overrun <= 1'b0;
    end else if (ev && (err_clear || !err_pending)) begin
      err_pending <= 1'b1;
      err_code    <= rsp_code;
      err_addr    <= s_addr;
      err_overrun <= 1'b0;
    end else if (ev) begin
      err_overrun <= 1'b1;
    end else if (err_clear) begin
      err_pending <= 1'b0;
      err_code    <= ERR_NONE;
      err_addr    <= '0;
      err_overrun <= 1'b0;
    end
  end

  assign err_irq = err_pending;

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Directed bench for picosoc_bus_fabric with a transaction-level model
// and a per-cycle compare process.
module tb_picosoc_bus_fabric;

  localparam int NSLV = 4;
  localparam int TMO  = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [NSLV*32-1:0] BASES =
    {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
  localparam logic [NSLV*32-1:0] MASKS = {NSLV{32'hFF00_0000}};

  logic              clk;
  logic              reset;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [NSLV-1:0]   s_valid;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NSLV-1:0]   s_ready;
  logic [NSLV*32-1:0] s_rdata;
  logic              err_clear;
  logic              err_irq;
  logic [1:0]        err_code;
  logic [31:0]       err_addr;
  logic              err_overrun;

  picosoc_bus_fabric #(
    .NSLV      (NSLV),
    .ADDR_BASE (BASES),
    .ADDR_MASK (MASKS),
    .TIMEOUT   (TMO),
    .ERR_RDATA (ERRD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .err_clear   (err_clear),
    .err_irq     (err_irq),
    .err_code    (err_code),
    .err_addr    (err_addr),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave i owns addresses whose top byte equals i.
  int          wait_cfg [NSLV] = '{1, 3, 0, 1000};
  logic [31:0] rd_cfg   [NSLV] = '{32'hCAFE_0000, 32'h1111_2222,
                                   32'h1234_5678, 32'h3333_4444};
  int              wcnt [NSLV];
  logic [NSLV-1:0] stray;

  always_comb begin
    s_ready = '0;
    s_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      s_ready[i] = stray[i] | (s_valid[i] && (wcnt[i] == wait_cfg[i]));
      s_rdata[i*32 +: 32] = rd_cfg[i];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < NSLV; i++)
      wcnt[i] <= s_valid[i] ? wcnt[i] + 1 : 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e)
      $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
    else
      passed++;
  endtask

  bit          act = 0;
  int          t0 = 0;
  int          lat = 0;
  bit          m_hit;
  logic [3:0]  m_onehot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_rdata;
  logic [1:0]  m_ecode;
  bit          e_pend = 0;
  bit          e_ovr = 0;
  logic [1:0]  e_code = 2'b00;
  logic [31:0] e_addr = 32'h0;

  int          obs_rel;
  logic [31:0] obs_data;
  logic [3:0]  obs_sv1;
  int          obs_stable;

  always @(negedge clk) begin
    int rel;
    logic erdy;
    logic [3:0] esv;
    rel  = cyc - t0;
    erdy = act && (rel == lat);
    esv  = (act && m_hit && rel >= 1 && rel < lat) ? m_onehot : 4'h0;
    chk("mem_ready", mem_ready, erdy);
    chk("s_valid", s_valid, esv);
    if (erdy) chk("mem_rdata", mem_rdata, m_rdata);
    if (esv != 4'h0) begin
      chk("s_addr", s_addr, m_addr);
      chk("s_wdata", s_wdata, m_wdata);
      chk("s_wstrb", s_wstrb, m_wstrb);
    end
    chk("err_irq", err_irq, e_pend);
    chk("err_code", err_code, e_code);
    chk("err_addr", err_addr, e_addr);
    chk("err_overrun", err_overrun, e_ovr);
    if (act && mem_ready) begin
      obs_rel  = rel;
      obs_data = mem_rdata;
    end
    if (act && rel == 1) obs_sv1 = s_valid;
    if (act && s_valid != 0 && s_wdata == m_wdata && s_wstrb == m_wstrb)
      obs_stable++;
  end

  task automatic setup_model(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws);
    int s;
    int w;
    m_hit = (a[31:24] < NSLV);
    if (m_hit) begin
      s = int'(a[31:24]);
      w = wait_cfg[s];
      m_onehot = 4'b0001 << s;
      if (w >= TMO) begin
        lat = TMO + 1;
        m_rdata = ERRD;
        m_ecode = 2'b10;
      end else begin
        lat = 2 + w;
        m_rdata = rd_cfg[s];
        m_ecode = 2'b00;
      end
    end else begin
      m_onehot = 4'h0;
      lat = 1;
      m_rdata = ERRD;
      m_ecode = 2'b01;
    end
    m_addr = a;
    m_wdata = wd;
    m_wstrb = ws;
    obs_rel = -1;
    obs_data = 32'h0;
    obs_sv1 = 4'h0;
    obs_stable = 0;
    t0 = cyc;
    act = 1;
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input bit clr);
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    setup_model(a, wd, ws);
    repeat (lat) @(posedge clk);
    #1 err_clear = clr;
    @(posedge clk); #1;
    err_clear = 1'b0;
    mem_valid = 1'b0;
    act = 0;
    if (m_ecode != 2'b00) begin
      if (clr || !e_pend) begin
        e_pend = 1; e_code = m_ecode; e_addr = a; e_ovr = 0;
      end else begin
        e_ovr = 1;
      end
    end else if (clr) begin
      e_pend = 0; e_code = 2'b00; e_addr = 32'h0; e_ovr = 0;
    end
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    e_pend = 0; e_code = 2'b00; e_addr = 32'h0; e_ovr = 0;
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    err_clear = 1'b0;
    stray = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_svalid", s_valid, 4'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_irq", err_irq, 1'b0);
    reset = 1'b0;

    txn(32'h0200_0010, 32'h0, 4'h0, 0);
    chk("rd_sv1", obs_sv1, 4'b0100);
    chk("rd_lat", obs_rel, 2);
    chk("rd_data", obs_data, 32'h1234_5678);

    txn(32'h0100_0040, 32'hA5A5_A5A5, 4'b0011, 0);
    chk("wr_lat", obs_rel, 5);
    chk("wr_stable", obs_stable, 4);
    chk("wr_noerr", err_irq, 1'b0);

    txn(32'h0000_0100, 32'h0, 4'h0, 0);
    chk("rd0_lat", obs_rel, 3);
    chk("rd0_data", obs_data, 32'hCAFE_0000);

    txn(32'hF000_0000, 32'h0, 4'h0, 0);
    chk("miss_lat", obs_rel, 1);
    chk("miss_data", obs_data, 32'hDEAD_BEEF);
    chk("miss_irq", err_irq, 1'b1);
    chk("miss_code", err_code, 2'b01);
    chk("miss_addr", err_addr, 32'hF000_0000);

    clear_err();
    chk("clr_irq", err_irq, 1'b0);

    stray = 4'b0001;
    txn(32'h0300_0004, 32'h0, 4'h0, 0);
    stray = '0;
    chk("tmo_sv1", obs_sv1, 4'b1000);
    chk("tmo_lat", obs_rel, 9);
    chk("tmo_data", obs_data, 32'hDEAD_BEEF);
    chk("tmo_code", err_code, 2'b10);

    txn(32'hF100_0000, 32'h0, 4'h0, 0);
    chk("ovr_flag", err_overrun, 1'b1);
    chk("ovr_addr", err_addr, 32'h0300_0004);
    chk("ovr_code", err_code, 2'b10);

    txn(32'hF200_0000, 32'h0, 4'h0, 1);
    chk("col_irq", err_irq, 1'b1);
    chk("col_addr", err_addr, 32'hF200_0000);
    chk("col_code", err_code, 2'b01);
    chk("col_ovr", err_overrun, 1'b0);

    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h0300_0008;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    setup_model(32'h0300_0008, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    act = 0;
    mem_valid = 1'b0;
    e_pend = 0; e_code = 2'b00; e_addr = 32'h0; e_ovr = 0;
    #1;
    chk("ar_svalid", s_valid, 4'h0);
    chk("ar_ready", mem_ready, 1'b0);
    chk("ar_rdata", mem_rdata, 32'h0);
    chk("ar_saddr", s_addr, 32'h0);
    chk("ar_swdata", s_wdata, 32'h0);
    chk("ar_swstrb", s_wstrb, 4'h0);
    chk("ar_irq", err_irq, 1'b0);
    chk("ar_code", err_code, 2'b00);
    chk("ar_eaddr", err_addr, 32'h0);
    chk("ar_ovr", err_overrun, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/picosoc_bus_fabric.md
# picosoc_bus_fabric

Parametrised single-master, N-slave bus fabric for the PicoSoC native memory interface (valid/ready/addr/wdata/wstrb/rdata). It replaces hand-written per-peripheral select and ready/rdata muxing with base/mask address windows. It also adds behaviour the flat decode lacks: registered slave selection, a per-transaction timeout watchdog, and sticky error capture with an interrupt. It sits between the picorv32 core and the RAM, SPI flash, UART and iomem slaves.

## Interface
- `NSLV`, 4: number of slave ports (1..16).
- `ADDR_BASE`, {NSLV{32'h0}}: packed NSLV×32. Slave i hits when `(addr & ADDR_MASK[i]) == ADDR_BASE[i]`.
- `ADDR_MASK`, {NSLV{32'hFFFF_FFFF}}: packed NSLV×32 window masks.
- `TIMEOUT`, 255: maximum cycles in ACTIVE waiting for `s_ready`. 0 disables the watchdog.
- `ERR_RDATA`, 32'h0000_0000: read data returned on miss or timeout.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: master request.
- `mem_addr` in 32: master address.
- `mem_wdata` in 32: master write data.
- `mem_wstrb` in 4: master byte strobes; 0 means read.
- `mem_ready` out 1: one-cycle response pulse.
- `mem_rdata` out 32: response data, valid while `mem_ready`.
- `s_valid` out NSLV: one-hot slave request.
- `s_addr` out 32, `s_wdata` out 32, `s_wstrb` out 4: registered copies of the request, shared by all slaves.
- `s_ready` in NSLV: per-slave ready.
- `s_rdata` in NSLV×32: per-slave read data, packed.
- `err_clear` in 1: clears error status.
- `err_irq` out 1: equals `err_pending`.
- `err_code` out 2: 01 decode miss, 10 timeout.
- `err_addr` out 32: address of the first captured error.
- `err_overrun` out 1: set when another error occurs while `err_pending` is set.

## Operation
- FSM states: IDLE, ACTIVE, RESP.
- IDLE with `mem_valid`:
  - Decode; the lowest-index hit wins.
  - Latch the select, `s_addr`, `s_wdata` and `s_wstrb`.
  - On a hit, go to ACTIVE. On a miss, go to RESP with `ERR_RDATA` and raise an error (code 01).
- ACTIVE:
  - `s_valid[sel]` is held high and the request registers are held stable.
  - On `s_ready[sel]`: capture `s_rdata[sel]`, go to RESP.
  - Ready from non-selected slaves is ignored.
- Watchdog: the counter increments in each ACTIVE cycle without ready. Width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps. When it reaches `TIMEOUT`, drop `s_valid`, go to RESP with `ERR_RDATA`, and raise an error (code 10).
- RESP: `mem_ready` = 1 for exactly one cycle, `s_valid` = 0, then return to IDLE.
- Error capture:
  - The first error sets `err_pending`, `err_code` and `err_addr`.
  - A later error while pending sets only `err_overrun`.
  - `err_clear` clears all four error fields.
  - If a new error and `err_clear` occur in the same cycle, the new error is captured and `err_overrun` = 0.
- Reset: asynchronous.
  - Every output goes to 0 (`mem_ready`, `mem_rdata`, `s_valid`, `s_addr`, `s_wdata`, `s_wstrb`, and all `err_*`).
  - FSM to IDLE, counter to 0.
  - Reset mid-transaction aborts with no response. The slave sees `s_valid` fall.

## Timing
- Request seen at cycle 0 in IDLE. `s_valid` is high at cycle 1. If `s_ready` is high at cycle 1, `mem_ready` pulses at cycle 2. Minimum latency is 2 cycles.
- Slave wait of k cycles gives `mem_ready` at cycle 2+k.
- Miss: `mem_ready` at cycle 1, and `err_irq` high from cycle 2.
- Timeout: `s_valid` is high for cycles 1..TIMEOUT and `mem_ready` pulses at cycle TIMEOUT+1.
- `mem_valid` is not sampled in RESP. The next request is accepted in IDLE at the earliest one cycle after the `mem_ready` pulse.

## Structure
- Package `picosoc_bus_pkg` holds:
  - the FSM state enum;
  - the error-code constants `ERR_NONE`, `ERR_MISS`, `ERR_TIMEOUT`;
  - the default `ERR_RDATA`.
- Sub-module `picosoc_addr_decode`: combinational base/mask match, priority encoder, and hit flag; parametrised by `NSLV`.
- The FSM, watchdog, response mux and error registers stay in the top module.

## Test plan
- Read hit:
  - Setup: NSLV=4, slave 2 at base 0x0200_0000, mask 0xFF00_0000, returning 0x1234_5678 with 0 wait.
  - Stimulus: read 0x0200_0010.
  - Required response: `s_valid` = 4'b0100 at cycle 1, `mem_ready` at cycle 2, `mem_rdata` = 0x1234_5678.
- Write with wait states:
  - Stimulus: write 0xA5A5_A5A5, `wstrb` 4'b0011, to a slave holding ready low for 3 cycles.
  - Required response: `s_wstrb`/`s_wdata` stable for 4 cycles, `mem_ready` at cycle 5, no error.
- Decode miss:
  - Stimulus: access 0xF000_0000 with no matching window.
  - Required response: `mem_ready` at cycle 1 with `ERR_RDATA`, `err_irq` = 1, `err_code` = 01, `err_addr` = 0xF000_0000.
- Timeout and overrun:
  - Setup: TIMEOUT = 8, slave never ready.
  - Required response: `mem_ready` at cycle 9, `err_code` = 10.
  - A second miss while pending sets `err_overrun` = 1; `err_addr` is unchanged.
- Clear collision, then reset:
  - Stimulus: `err_clear` in the same cycle as a new miss. Then assert `reset` while in ACTIVE.
  - Required response: the new error is captured with `err_overrun` = 0. On reset, all outputs go to 0 immediately, and no `mem_ready` follows.
